// File: rtl/pmem_arbiter.sv
// Round-robin arbiter funnelling several fetcher read ports into the single
// program-memory cache read channel, one transaction at a time.
module pmem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 2,
    localparam int IDXW         = $clog2(NUM_CONSUMERS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    output logic                     cache_read_valid,
    output logic [ADDR_BITS-1:0]     cache_read_address,
    input  logic                     cache_read_ready,
    input  logic [DATA_BITS-1:0]     cache_read_data,
    output logic [IDXW-1:0]          grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RELAY, DRAIN} state_t;

    state_t                     state_q;
    logic [IDXW-1:0]            rr_ptr_q;
    logic [IDXW-1:0]            owner_q;
    logic [IDXW-1:0]            grant_q;
    logic                       cvalid_q;
    logic [ADDR_BITS-1:0]       caddr_q;
    logic [NUM_CONSUMERS-1:0]   cready_q;
    logic [DATA_BITS-1:0]       cdata_q [NUM_CONSUMERS];

    logic [IDXW-1:0]            winner_d;
    logic                       found_d;

    // First requester after the last owner, wrapping, so every port is served in turn.
    always_comb begin : pick
        logic [IDXW-1:0] idx;
        idx      = '0;
        winner_d = '0;
        found_d  = 1'b0;
        for (int k = 1; k <= NUM_CONSUMERS; k++) begin
            idx = IDXW'((int'(rr_ptr_q) + k) % NUM_CONSUMERS);
            if (!found_d && consumer_read_valid[idx]) begin
                found_d  = 1'b1;
                winner_d = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDXW'(NUM_CONSUMERS - 1);
            owner_q  <= '0;
            grant_q  <= '0;
            cvalid_q <= 1'b0;
            caddr_q  <= '0;
            cready_q <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                cdata_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        owner_q  <= winner_d;
                        grant_q  <= winner_d;
                        caddr_q  <= consumer_read_address[winner_d];
                        cvalid_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cache_read_ready) begin
                        cvalid_q          <= 1'b0;
                        cdata_q[owner_q]  <= cache_read_data;
                        cready_q[owner_q] <= 1'b1;
                        rr_ptr_q          <= owner_q;
                        state_q           <= RELAY;
                    end
                end
                RELAY: begin
                    if (!consumer_read_valid[owner_q]) begin
                        cready_q[owner_q] <= 1'b0;
                        cdata_q[owner_q]  <= '0;
                        // The cache may still be holding ready; wait it out before re-arbitrating.
                        state_q           <= cache_read_ready ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (!cache_read_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign consumer_read_ready = cready_q;
    assign consumer_read_data  = cdata_q;
    assign cache_read_valid    = cvalid_q;
    assign cache_read_address  = caddr_q;
    assign grant_id            = grant_q;
    assign busy                = (state_q != IDLE);

endmodule
